// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, IDLE/RUN/HALTED control and a one-entry output stage.
// Optional INSTR_FETCH_CNT_EN adds fetch_cnt_o, a saturating count of accepted instructions.
module instr_fetch #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        halt_i,
  input  logic        redirect_i,
  input  logic [7:0]  redirect_pc_i,
  output logic [7:0]  addr_read_o,
  input  logic [31:0] data_read_i,
  output logic [31:0] instr_o,
  output logic [7:0]  pc_o,
  output logic        valid_o,
  input  logic        ready_i,
`ifdef INSTR_FETCH_CNT_EN
  output logic        busy_o,
  output logic [15:0] fetch_cnt_o
`else
  output logic        busy_o
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_d;
  logic [7:0]  r_pc;
  logic [31:0] r_instr;
  logic [7:0]  r_pc_out;
  logic        r_valid;
  logic        w_accept;
  logic        w_fetch;

  // Output stage may be (re)loaded when empty or when its content is taken this edge.
  assign w_accept = !r_valid || ready_i;
  assign w_fetch  = (r_state == ST_RUN) && !redirect_i && !halt_i && w_accept;

  assign addr_read_o = r_pc;
  assign instr_o     = r_instr;
  assign pc_o        = r_pc_out;
  assign valid_o     = r_valid;
  assign busy_o      = (r_state == ST_RUN);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (halt_i) w_state_d = ST_HALTED;
      end
      ST_IDLE, ST_HALTED: begin
        // halt_i beats a simultaneous start_i
        if (start_i && !halt_i) w_state_d = ST_RUN;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= 32'h0;
      r_pc_out <= 8'h00;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (redirect_i) begin
        r_pc    <= redirect_pc_i;
        r_valid <= 1'b0;
      end else if (w_fetch) begin
        r_instr  <= data_read_i;
        r_pc_out <= r_pc;
        r_valid  <= 1'b1;
        r_pc     <= r_pc + 8'd1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef INSTR_FETCH_CNT_EN
  logic [15:0] r_cnt;

  assign fetch_cnt_o = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'h0;
    end else if (r_valid && ready_i && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, wrap/reset/halt sequences and
// randomized traffic against a behavioural model. Define INSTR_FETCH_CNT_EN to cover the counter.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, halt_i, redirect_i, ready_i;
  logic [7:0]  redirect_pc_i;
  logic [7:0]  addr_a, addr_b, pc_a, pc_b;
  logic [31:0] data_a, data_b, instr_a, instr_b;
  logic        valid_a, valid_b, busy_a, busy_b;
`ifdef INSTR_FETCH_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  logic [31:0] mem [256];
  assign data_a = mem[addr_a];
  assign data_b = mem[addr_b];

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(8'h00)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .halt_i(halt_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .addr_read_o(addr_a), .data_read_i(data_a),
    .instr_o(instr_a), .pc_o(pc_a), .valid_o(valid_a), .ready_i(ready_i),
`ifdef INSTR_FETCH_CNT_EN
    .fetch_cnt_o(cnt_a),
`endif
    .busy_o(busy_a)
  );

  instr_fetch #(.RESET_PC(8'hFE)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .halt_i(halt_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .addr_read_o(addr_b), .data_read_i(data_b),
    .instr_o(instr_b), .pc_o(pc_b), .valid_o(valid_b), .ready_i(ready_i),
`ifdef INSTR_FETCH_CNT_EN
    .fetch_cnt_o(cnt_b),
`endif
    .busy_o(busy_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 0; halt_i = 0; redirect_i = 0; redirect_pc_i = 8'h00; ready_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    #2;
    @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic        start, halt, redir;
    logic [7:0]  rpc;
    logic        ready;
    logic        e_valid;
    logic [7:0]  e_pc;
    logic [31:0] e_instr;
    logic        e_busy;
    logic [7:0]  e_addr;
  } vec_t;

  vec_t vt[22];

  // Behavioural model: one outstanding-instruction slot plus a running flag.
  bit          m_running;
  int          m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_pcout;
  int          m_cnt;

  task automatic model_reset();
    m_running = 0; m_pc = 0; m_valid = 0; m_instr = 0; m_pcout = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit can_load, do_fetch;
    can_load = !m_valid || ready_i;
    do_fetch = m_running && !redirect_i && !halt_i && can_load;
    if (m_valid && ready_i && m_cnt < 65535) m_cnt++;
    if (redirect_i) begin
      m_pc = redirect_pc_i; m_valid = 0;
    end else if (do_fetch) begin
      m_instr = mem[m_pc]; m_pcout = m_pc; m_valid = 1; m_pc = (m_pc + 1) % 256;
    end else if (can_load) begin
      m_valid = 0;
    end
    if (m_running && halt_i) m_running = 0;
    else if (!m_running && start_i && !halt_i) m_running = 1;
  endtask

  initial begin
    logic [7:0] wrap_exp[4];
    rst_n = 1;
    idle_inputs();
    for (int i = 0; i < 256; i++) mem[i] = i + 100;

    // Reset values, checked while reset is held
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rst_valid", {31'b0, valid_a}, 32'd0);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_addr", {24'b0, addr_a}, 32'h00);
    check("rst_addr_b", {24'b0, addr_b}, 32'hFE);
    check("rst_pc_o", {24'b0, pc_b}, 32'h00);
    check("rst_instr", instr_a, 32'h0);
    @(negedge clk);
    rst_n = 1;

    //        start halt redir rpc   rdy  e_v e_pc   e_instr e_busy e_addr
    vt[0]  = '{1, 0, 0, 8'h00, 1,  0, 8'h00, 0,   1, 8'h00};
    vt[1]  = '{0, 0, 0, 8'h00, 1,  1, 8'h00, 100, 1, 8'h01};
    vt[2]  = '{0, 0, 0, 8'h00, 1,  1, 8'h01, 101, 1, 8'h02};
    vt[3]  = '{0, 0, 0, 8'h00, 1,  1, 8'h02, 102, 1, 8'h03};
    vt[4]  = '{0, 0, 0, 8'h00, 1,  1, 8'h03, 103, 1, 8'h04};
    vt[5]  = '{0, 0, 0, 8'h00, 1,  1, 8'h04, 104, 1, 8'h05};
    vt[6]  = '{0, 0, 0, 8'h00, 1,  1, 8'h05, 105, 1, 8'h06};
    vt[7]  = '{0, 0, 0, 8'h00, 0,  1, 8'h05, 105, 1, 8'h06};
    vt[8]  = '{0, 0, 0, 8'h00, 0,  1, 8'h05, 105, 1, 8'h06};
    vt[9]  = '{0, 0, 0, 8'h00, 0,  1, 8'h05, 105, 1, 8'h06};
    vt[10] = '{0, 0, 0, 8'h00, 1,  1, 8'h06, 106, 1, 8'h07};
    vt[11] = '{0, 0, 1, 8'h40, 0,  0, 8'h00, 0,   1, 8'h40};
    vt[12] = '{0, 0, 0, 8'h00, 1,  1, 8'h40, 164, 1, 8'h41};
    vt[13] = '{1, 1, 0, 8'h00, 1,  0, 8'h00, 0,   0, 8'h41};
    vt[14] = '{0, 0, 0, 8'h00, 1,  0, 8'h00, 0,   0, 8'h41};
    vt[15] = '{1, 0, 0, 8'h00, 1,  0, 8'h00, 0,   1, 8'h41};
    vt[16] = '{0, 0, 0, 8'h00, 1,  1, 8'h41, 165, 1, 8'h42};
    vt[17] = '{0, 1, 0, 8'h00, 0,  1, 8'h41, 165, 0, 8'h42};
    vt[18] = '{0, 0, 0, 8'h00, 0,  1, 8'h41, 165, 0, 8'h42};
    vt[19] = '{0, 0, 0, 8'h00, 1,  0, 8'h00, 0,   0, 8'h42};
    vt[20] = '{1, 0, 1, 8'h10, 1,  0, 8'h00, 0,   1, 8'h10};
    vt[21] = '{0, 0, 0, 8'h00, 1,  1, 8'h10, 116, 1, 8'h11};

    for (int i = 0; i < 22; i++) begin
      start_i = vt[i].start; halt_i = vt[i].halt; redirect_i = vt[i].redir;
      redirect_pc_i = vt[i].rpc; ready_i = vt[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), {31'b0, valid_a}, {31'b0, vt[i].e_valid});
      check($sformatf("vec%0d_busy", i), {31'b0, busy_a}, {31'b0, vt[i].e_busy});
      check($sformatf("vec%0d_addr", i), {24'b0, addr_a}, {24'b0, vt[i].e_addr});
      if (vt[i].e_valid) begin
        check($sformatf("vec%0d_pc", i), {24'b0, pc_a}, {24'b0, vt[i].e_pc});
        check($sformatf("vec%0d_instr", i), instr_a, vt[i].e_instr);
      end
    end

    // PC wrap on the FE-reset instance
    do_reset();
    wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
    start_i = 1; ready_i = 1;
    tick();
    start_i = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("wrap%0d_valid", i), {31'b0, valid_b}, 32'd1);
      check($sformatf("wrap%0d_pc", i), {24'b0, pc_b}, {24'b0, wrap_exp[i]});
    end

    // Reset mid-transfer discards the held instruction, then stays idle
    ready_i = 0;
    tick();
    check("midrst_pre_valid", {31'b0, valid_a}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    check("midrst_valid", {31'b0, valid_a}, 32'd0);
    check("midrst_addr", {24'b0, addr_a}, 32'h00);
`ifdef INSTR_FETCH_CNT_EN
    check("midrst_cnt", {16'b0, cnt_a}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1;
    ready_i = 1;
    repeat (3) tick();
    check("postrst_valid", {31'b0, valid_a}, 32'd0);
    check("postrst_busy", {31'b0, busy_a}, 32'd0);

`ifdef INSTR_FETCH_CNT_EN
    // Ten transfers, then saturation
    do_reset();
    start_i = 1; ready_i = 1;
    tick();
    start_i = 0;
    repeat (11) tick();
    ready_i = 0;
    tick();
    check("cnt_ten", {16'b0, cnt_a}, 32'd10);
    ready_i = 1;
    repeat (65540) tick();
    check("cnt_sat", {16'b0, cnt_a}, 32'h0000FFFF);
    #2;
    rst_n = 0;
    #1;
    check("cnt_async_clr", {16'b0, cnt_a}, 32'd0);
    check("cnt_async_valid", {31'b0, valid_a}, 32'd0);
    @(negedge clk);
    rst_n = 1;
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      start_i = ($urandom_range(0, 9) == 0);
      halt_i = ($urandom_range(0, 19) == 0);
      redirect_i = ($urandom_range(0, 24) == 0);
      redirect_pc_i = 8'($urandom);
      ready_i = ($urandom_range(0, 9) < 7);
      model_step();
      tick();
      check("rnd_valid", {31'b0, valid_a}, {31'b0, m_valid});
      check("rnd_busy", {31'b0, busy_a}, {31'b0, m_running});
      check("rnd_addr", {24'b0, addr_a}, 32'(m_pc));
      if (m_valid) begin
        check("rnd_pc", {24'b0, pc_a}, 32'(m_pcout));
        check("rnd_instr", instr_a, m_instr);
      end
`ifdef INSTR_FETCH_CNT_EN
      check("rnd_cnt", {16'b0, cnt_a}, 32'(m_cnt));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded at reset.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  pulse; begin or resume fetching.
REQ-006 halt_i  input  1  pulse; stop issuing new fetches.
REQ-007 redirect_i  input  1  branch/jump taken; load redirect_pc_i and flush.
REQ-008 redirect_pc_i  input  8  word address of redirect target.
REQ-009 addr_read_o  output  8  instruction memory word address.
REQ-010 data_read_i  input  32  instruction memory combinational read data.
REQ-011 instr_o  output  32  fetched instruction to decode.
REQ-012 pc_o  output  8  word address of instr_o.
REQ-013 valid_o  output  1  instr_o/pc_o valid.
REQ-014 ready_i  input  1  decode accepts instr_o this cycle.
REQ-015 busy_o  output  1  high while state is RUN.

Function
REQ-016 States SHALL be IDLE, RUN and HALTED; busy_o SHALL be combinational from state.
REQ-017 addr_read_o SHALL equal the internal PC register combinationally, with no added latency.
REQ-018 Handshake: a transfer occurs on a rising edge with valid_o=1 and ready_i=1; while valid_o=1 and ready_i=0, instr_o, pc_o and valid_o SHALL hold.
REQ-019 Fetch: on an edge with state RUN, redirect_i=0, halt_i=0 and (valid_o=0 or ready_i=1), the block SHALL load instr_o<=data_read_i, pc_o<=PC, valid_o<=1, PC<=PC+1.
REQ-020 On an edge with (valid_o=0 or ready_i=1) and no fetch, valid_o SHALL clear.
REQ-021 PC SHALL wrap from 8'hFF to 8'h00 with no flag or stall.
REQ-022 redirect_i SHALL be honoured in every state: PC<=redirect_pc_i, valid_o<=0 next edge, regardless of ready_i; no fetch occurs that edge.
REQ-023 IDLE->RUN and HALTED->RUN on start_i; the first valid_o SHALL rise on the edge after the start_i edge.
REQ-024 RUN->HALTED on halt_i; no fetch on that edge; a held valid_o SHALL remain until accepted or flushed by redirect.
REQ-025 halt_i and start_i asserted together: halt_i SHALL win; start_i in RUN and halt_i outside RUN SHALL be ignored.
REQ-026 redirect_i together with halt_i: PC SHALL load redirect_pc_i and state SHALL go to HALTED.
REQ-027 redirect_i together with start_i in IDLE/HALTED: PC SHALL load redirect_pc_i, state SHALL go to RUN, and the first fetch SHALL be from redirect_pc_i.

Reset
REQ-028 rst_n low SHALL immediately set state IDLE, PC=RESET_PC, valid_o=0, instr_o=32'h0, pc_o=8'h00 and fetch_cnt_o (when present) =16'h0, independent of clk.
REQ-029 Reset asserted mid-transfer SHALL discard the pending instruction; after release the block SHALL stay in IDLE until start_i.

Configuration
REQ-030 With macro INSTR_FETCH_CNT_EN defined, the block SHALL add port fetch_cnt_o  output  16: saturating count of completed transfers, holding at 16'hFFFF.
REQ-031 Without INSTR_FETCH_CNT_EN, port fetch_cnt_o and its register SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, memory word[n]=n+100, start_i, ready_i=1 -> valid_o from the 2nd edge after start_i, pc_o 0,1,2 with instr_o 100,101,102 on consecutive cycles.
REQ-033 Backpressure: ready_i=0 for 3 cycles while valid_o=1 with pc_o=5 -> instr_o/pc_o hold, addr_read_o stays 6; after ready_i=1 the next transfer is pc_o=6.
REQ-034 Redirect to 8'h40 while valid_o=1, ready_i=0 -> valid_o=0 on the next edge, addr_read_o=8'h40, next transfer pc_o=8'h40.
REQ-035 RESET_PC=8'hFE, free-running -> pc_o sequence FE, FF, 00, 01.
REQ-036 halt_i and start_i on the same edge in RUN -> state HALTED, busy_o=0, no new fetch; a later start_i resumes from the held PC.
REQ-037 With INSTR_FETCH_CNT_EN: 10 transfers give fetch_cnt_o=10; a counter preloaded near the limit saturates at 16'hFFFF; rst_n low mid-stream clears the counter and valid_o asynchronously.
